// File: rtl/sys_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sys_bus_arbiter_if
//  Description : Signal bundle between the two cache controllers, the shared
//                system-memory port and the bus arbiter.
//
//                Requester side (per cache, prefix i_ = instruction cache,
//                d_ = data cache):
//                  *_req    level request, held until the matching ack
//                  *_rw     direction, 1 = read, 0 = write
//                  *_addr   access address
//                  *_wdata  write data
//                  *_ack    one-cycle completion pulse
//                  rdata    read data broadcast to both caches (ack cycle only)
//                Memory side:
//                  mem_strobe, mem_rw, mem_addr, mem_wdata  -> memory
//                  mem_rdata                                <- memory
//                Status:
//                  busy     arbiter is running an access
//
//                Modports:
//                  slave  - the arbiter (serves requests, drives memory)
//                  master - the environment (caches + memory model)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sys_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Instruction-cache requester
  logic          i_req;
  logic          i_rw;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic          i_ack;

  // Data-cache requester
  logic          d_req;
  logic          d_rw;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;

  // Shared read-data return
  logic [DW-1:0] rdata;

  // System-memory port
  logic          mem_strobe;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Status
  logic          busy;

  modport slave (
    input  i_req, i_rw, i_addr, i_wdata,
    input  d_req, d_rw, d_addr, d_wdata,
    input  mem_rdata,
    output i_ack, d_ack, rdata,
    output mem_strobe, mem_rw, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output i_req, i_rw, i_addr, i_wdata,
    output d_req, d_rw, d_addr, d_wdata,
    output mem_rdata,
    input  i_ack, d_ack, rdata,
    input  mem_strobe, mem_rw, mem_addr, mem_wdata,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sys_bus_arbiter
//  Description : Shares the single system-memory port between the I-cache
//                and D-cache controllers. One requester is picked in IDLE,
//                the memory port is driven for a fixed wait-state window and
//                the winner then receives a one-cycle ack. D has fixed
//                priority; a streak counter hands the port to I after
//                MAX_D_BURST consecutive D grants taken while I was waiting.
//
//  Ports       : clk  - system clock, all state updates on posedge
//                rst  - synchronous active-high reset
//                bus  - sys_bus_arbiter_if.slave (requests, acks, rdata,
//                       memory port, busy)
//
//  Parameters  : AW          address width
//                DW          data width
//                WAIT_STATES memory wait cycles per access (0..15)
//                MAX_D_BURST max consecutive D grants while I waits (1..15)
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_bus_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 2,
  parameter int MAX_D_BURST = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  sys_bus_arbiter_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // --------------------------------------------------------------------------
  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait_states
    $error("sys_bus_arbiter: WAIT_STATES must be in 0..15");
  end

  if ((MAX_D_BURST < 1) || (MAX_D_BURST > 15)) begin : g_bad_max_d_burst
    $error("sys_bus_arbiter: MAX_D_BURST must be in 1..15");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_BURST);

  // gsel encoding: which requester owns the current access
  localparam logic GSEL_D = 1'b0;
  localparam logic GSEL_I = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t     state_q,    state_d;
  logic       gsel_q,     gsel_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] d_streak_q, d_streak_d;

  // Requester fields selected by the registered grant
  logic          sel_rw;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gsel_q     <= GSEL_D;
      wait_cnt_q <= 4'd0;
      d_streak_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      gsel_q     <= gsel_d;
      wait_cnt_q <= wait_cnt_d;
      d_streak_q <= d_streak_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    gsel_d     = gsel_q;
    wait_cnt_d = wait_cnt_q;
    d_streak_d = d_streak_q;

    case (state_q)
      ST_IDLE: begin
        // The streak only measures D grants that made I wait, so any idle
        // cycle without an I request clears it.
        if (!bus.i_req) begin
          d_streak_d = 4'd0;
        end

        if (bus.d_req && !(bus.i_req && (d_streak_q == STREAK_MAX))) begin
          gsel_d  = GSEL_D;
          state_d = ST_GRANT;
          if (bus.i_req && (d_streak_q != STREAK_MAX)) begin
            d_streak_d = d_streak_q + 4'd1;
          end
        end else if (bus.i_req) begin
          gsel_d     = GSEL_I;
          state_d    = ST_GRANT;
          d_streak_d = 4'd0;
        end
      end

      ST_GRANT: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = (WAIT_INIT == 4'd0) ? ST_DONE : ST_WAIT;
      end

      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        // "<= 1" rather than "== 1" so a corrupted zero count still exits.
        if (wait_cnt_q <= 4'd1) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant multiplexer: driven only by the registered gsel, never by *_req
  // --------------------------------------------------------------------------
  always_comb begin
    sel_rw    = bus.d_rw;
    sel_addr  = bus.d_addr;
    sel_wdata = bus.d_wdata;
    if (gsel_q == GSEL_I) begin
      sel_rw    = bus.i_rw;
      sel_addr  = bus.i_addr;
      sel_wdata = bus.i_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from the registered state and grant only
  // --------------------------------------------------------------------------
  always_comb begin
    bus.busy       = 1'b0;
    bus.mem_strobe = 1'b0;
    bus.mem_rw     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.i_ack      = 1'b0;
    bus.d_ack      = 1'b0;
    bus.rdata      = '0;

    if (state_q != ST_IDLE) begin
      bus.busy       = 1'b1;
      bus.mem_strobe = 1'b1;
      bus.mem_rw     = sel_rw;
      bus.mem_addr   = sel_addr;
      bus.mem_wdata  = sel_wdata;
    end

    if (state_q == ST_DONE) begin
      bus.i_ack = (gsel_q == GSEL_I);
      bus.d_ack = (gsel_q == GSEL_D);
      if (sel_rw) begin
        bus.rdata = bus.mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_bus_arbiter
//  Description : Self-checking bench for sys_bus_arbiter. dut_a runs with
//                WAIT_STATES=2 / MAX_D_BURST=4, dut_b with WAIT_STATES=0.
//                Stimulus pushes hand-computed expected accesses and state
//                probes into queues; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_bus_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
  sys_bus_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

  sys_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(2), .MAX_D_BURST(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sys_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(0), .MAX_D_BURST(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // --------------------------------------------------------------------------
  // Scoreboard types and storage
  // --------------------------------------------------------------------------
  typedef struct {
    bit            abort;  // access is killed by reset, no ack expected
    bit            side;   // 0 = D, 1 = I
    int            cyc;    // ack cycle (or first idle cycle for an abort)
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            len;    // strobe cycles expected for the access
  } exp_t;

  typedef struct {
    int         dut;
    int         cyc;
    bit         busy;
    bit         strobe;
    bit         chk_streak;
    logic [3:0] streak;
  } probe_t;

  typedef struct {
    bit            busy;
    bit            strobe;
    bit            rw;
    bit            i_ack;
    bit            d_ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [3:0]    streak;
  } obs_t;

  exp_t   qa[$];
  exp_t   qb[$];
  probe_t pq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  int scnt_a = 0;
  int scnt_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Check helpers (called from the monitor only)
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s %s cycle=%0d", name, detail, cyc);
  endtask

  function automatic bit q_has(input int k);
    if (k == 0) return qa.size() != 0;
    return qb.size() != 0;
  endfunction

  function automatic exp_t q_front(input int k);
    if (k == 0) return qa[0];
    return qb[0];
  endfunction

  task automatic q_pop(input int k);
    if (k == 0) begin
      void'(qa.pop_front());
      scnt_a = 0;
    end else begin
      void'(qb.pop_front());
      scnt_b = 0;
    end
  endtask

  task automatic observe(input int k, input obs_t o);
    exp_t e;
    bit   has;
    int   scnt;
    has = q_has(k);
    if (has) e = q_front(k);

    chk("ack_exclusive", 64'(o.i_ack & o.d_ack), 64'd0);

    if (o.strobe) begin
      if (k == 0) scnt_a++; else scnt_b++;
      if (!has) begin
        fail("stray_strobe", $sformatf("dut=%0d addr=0x%0h", k, o.addr));
      end else begin
        chk("mem_addr",  64'(o.addr),  64'(e.addr));
        chk("mem_rw",    64'(o.rw),    64'(e.rw));
        chk("mem_wdata", 64'(o.wdata), 64'(e.wdata));
      end
    end else begin
      chk("idle_mem_addr",     64'(o.addr), 64'd0);
      chk("idle_mem_wdata_rw", 64'({o.rw, o.wdata}), 64'd0);
    end

    scnt = (k == 0) ? scnt_a : scnt_b;

    if (o.i_ack || o.d_ack) begin
      if (!has || e.abort) begin
        fail("unexpected_ack", $sformatf("dut=%0d i_ack=%0d d_ack=%0d", k, o.i_ack, o.d_ack));
      end else begin
        chk("ack_side",   64'(o.i_ack), 64'(e.side));
        chk("ack_cycle",  64'(cyc),     64'(e.cyc));
        chk("ack_rdata",  64'(o.rdata), 64'(e.rdata));
        chk("strobe_len", 64'(scnt),    64'(e.len));
        q_pop(k);
      end
    end else begin
      chk("idle_rdata", 64'(o.rdata), 64'd0);
      if (has && e.abort && (cyc == e.cyc)) begin
        chk("abort_strobe", 64'(o.strobe), 64'd0);
        chk("abort_busy",   64'(o.busy),   64'd0);
        chk("abort_len",    64'(scnt),     64'(e.len));
        q_pop(k);
      end else if (has && (cyc > e.cyc)) begin
        fail("ack_timeout", $sformatf("dut=%0d side=%0d required_cycle=%0d", k, e.side, e.cyc));
        q_pop(k);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    obs_t   oa;
    obs_t   ob;
    obs_t   o;
    probe_t p;
    if (mon_en) begin
      oa.busy = bus_a.busy;       oa.strobe = bus_a.mem_strobe; oa.rw = bus_a.mem_rw;
      oa.i_ack = bus_a.i_ack;     oa.d_ack = bus_a.d_ack;       oa.addr = bus_a.mem_addr;
      oa.wdata = bus_a.mem_wdata; oa.rdata = bus_a.rdata;       oa.streak = dut_a.d_streak_q;
      ob.busy = bus_b.busy;       ob.strobe = bus_b.mem_strobe; ob.rw = bus_b.mem_rw;
      ob.i_ack = bus_b.i_ack;     ob.d_ack = bus_b.d_ack;       ob.addr = bus_b.mem_addr;
      ob.wdata = bus_b.mem_wdata; ob.rdata = bus_b.rdata;       ob.streak = dut_b.d_streak_q;
      observe(0, oa);
      observe(1, ob);
      while ((pq.size() != 0) && (pq[0].cyc <= cyc)) begin
        p = pq.pop_front();
        if (p.cyc < cyc) begin
          fail("probe_missed", $sformatf("dut=%0d probe_cycle=%0d", p.dut, p.cyc));
        end else begin
          o = (p.dut == 0) ? oa : ob;
          chk("probe_busy",   64'(o.busy),   64'(p.busy));
          chk("probe_strobe", 64'(o.strobe), 64'(p.strobe));
          if (p.chk_streak) chk("probe_d_streak", 64'(o.streak), 64'(p.streak));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input bit side, input int c, input bit rw,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] rdata, input int len, input bit abort);
    exp_t e;
    e.abort = abort; e.side = side; e.cyc = c; e.rw = rw;
    e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.len = len;
    if (k == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic probe(input int k, input int c, input bit busy, input bit strobe,
                       input bit cs, input logic [3:0] st);
    probe_t p;
    p.dut = k; p.cyc = c; p.busy = busy; p.strobe = strobe; p.chk_streak = cs; p.streak = st;
    pq.push_back(p);
  endtask

  // Wait (bounded) for the ack of one side, then drop that side's request.
  task automatic wait_ack(input int k, input bit side);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (k == 0) begin
        if (side ? bus_a.i_ack : bus_a.d_ack) begin
          if (side) bus_a.i_req = 1'b0; else bus_a.d_req = 1'b0;
          return;
        end
      end else begin
        if (side ? bus_b.i_ack : bus_b.d_ack) begin
          if (side) bus_b.i_req = 1'b0; else bus_b.d_req = 1'b0;
          return;
        end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    int base;
    bus_a.i_req = 0; bus_a.i_rw = 0; bus_a.i_addr = '0; bus_a.i_wdata = '0;
    bus_a.d_req = 0; bus_a.d_rw = 0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_a.mem_rdata = '0;
    bus_b.i_req = 0; bus_b.i_rw = 0; bus_b.i_addr = '0; bus_b.i_wdata = '0;
    bus_b.d_req = 0; bus_b.d_rw = 0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
    bus_b.mem_rdata = '0;

    // Reset state
    step(); step(); step();
    rst    = 1'b0;
    mon_en = 1'b1;
    probe(0, cyc, 0, 0, 1, 4'd0);
    probe(1, cyc, 0, 0, 1, 4'd0);
    step();

    // Single D read, W=2: strobe base+1..base+4, ack base+4
    base = cyc;
    bus_a.mem_rdata = 32'hDEADBEEF;
    bus_a.d_rw = 1; bus_a.d_addr = 32'h100; bus_a.d_wdata = 32'h55; bus_a.d_req = 1;
    push(0, 0, base + 4, 1, 32'h100, 32'h55, 32'hDEADBEEF, 4, 0);
    probe(0, base + 1, 1, 1, 0, 4'd0);
    probe(0, base + 5, 0, 0, 0, 4'd0);
    wait_ack(0, 0);
    step(); step();

    // Single I write, W=0: ack base+2, rdata 0 despite live mem_rdata
    base = cyc;
    bus_b.mem_rdata = 32'h99999999;
    bus_b.i_rw = 0; bus_b.i_addr = 32'h40; bus_b.i_wdata = 32'h12345678; bus_b.i_req = 1;
    push(1, 1, base + 2, 0, 32'h40, 32'h12345678, 32'h0, 2, 0);
    wait_ack(1, 1);
    step();

    // D read on W=0 right after: one IDLE cycle, then ack two cycles later
    base = cyc;
    bus_b.d_rw = 1; bus_b.d_addr = 32'h240; bus_b.d_wdata = 32'h0; bus_b.d_req = 1;
    push(1, 0, base + 2, 1, 32'h240, 32'h0, 32'h99999999, 2, 0);
    wait_ack(1, 0);
    step(); step();

    // Simultaneous requests: D ack base+4, I ack base+9
    base = cyc;
    bus_a.mem_rdata = 32'hCAFEF00D;
    bus_a.d_rw = 1; bus_a.d_addr = 32'h300; bus_a.d_wdata = 32'h11; bus_a.d_req = 1;
    bus_a.i_rw = 1; bus_a.i_addr = 32'h400; bus_a.i_wdata = 32'h22; bus_a.i_req = 1;
    push(0, 0, base + 4, 1, 32'h300, 32'h11, 32'hCAFEF00D, 4, 0);
    push(0, 1, base + 9, 1, 32'h400, 32'h22, 32'hCAFEF00D, 4, 0);
    probe(0, base + 1, 1, 1, 1, 4'd1);
    probe(0, base + 6, 1, 1, 1, 4'd0);
    wait_ack(0, 0);
    wait_ack(0, 1);
    step(); step();

    // Starvation guard: 4 D acks, then I, then D again
    base = cyc;
    bus_a.mem_rdata = 32'hA5A5A5A5;
    bus_a.d_rw = 0; bus_a.d_addr = 32'h500; bus_a.d_wdata = 32'hD0000000; bus_a.d_req = 1;
    bus_a.i_rw = 1; bus_a.i_addr = 32'h600; bus_a.i_wdata = 32'h0; bus_a.i_req = 1;
    for (int n = 0; n < 4; n++) begin
      push(0, 0, base + 4 + 5 * n, 0, 32'h500 + 32'(4 * n), 32'hD0000000 + 32'(n), 32'h0, 4, 0);
    end
    push(0, 1, base + 24, 1, 32'h600, 32'h0, 32'hA5A5A5A5, 4, 0);
    push(0, 0, base + 29, 0, 32'h510, 32'hD0000004, 32'h0, 4, 0);
    probe(0, base + 16, 1, 1, 1, 4'd4);
    probe(0, base + 21, 1, 1, 1, 4'd0);
    for (int n = 0; n < 4; n++) begin
      wait_ack(0, 0);
      step();
      bus_a.d_addr  = 32'h500 + 32'(4 * (n + 1));
      bus_a.d_wdata = 32'hD0000000 + 32'(n + 1);
      bus_a.d_req   = 1;
    end
    wait_ack(0, 1);
    wait_ack(0, 0);
    step(); step();

    // Reset during WAIT with D granted: no ack, port idle the next cycle
    base = cyc;
    bus_a.d_rw = 1; bus_a.d_addr = 32'h700; bus_a.d_wdata = 32'h77; bus_a.d_req = 1;
    push(0, 0, base + 3, 1, 32'h700, 32'h77, 32'h0, 2, 1);
    probe(0, base + 3, 0, 0, 1, 4'd0);
    step(); step();
    rst = 1'b1;
    bus_a.d_req = 0;
    step();
    rst = 1'b0;
    step(); step(); step();

    // Late I request during D WAIT: D address holds, I granted after d_ack
    base = cyc;
    bus_a.mem_rdata = 32'h0BADF00D;
    bus_a.d_rw = 1; bus_a.d_addr = 32'h800; bus_a.d_wdata = 32'h88; bus_a.d_req = 1;
    push(0, 0, base + 4, 1, 32'h800, 32'h88, 32'h0BADF00D, 4, 0);
    push(0, 1, base + 9, 1, 32'h900, 32'h99, 32'h0BADF00D, 4, 0);
    step(); step();
    bus_a.i_rw = 1; bus_a.i_addr = 32'h900; bus_a.i_wdata = 32'h99; bus_a.i_req = 1;
    wait_ack(0, 0);
    wait_ack(0, 1);
    step(); step();

    for (int n = 0; (n < 40) && ((qa.size() + qb.size() + pq.size()) != 0); n++) step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Shares the single system-memory port between the instruction-cache controller and the data-cache controller.
- Each cache controller raises a level request, which replaces its direct SysStrobe/SysRW connection to memory.
- The arbiter picks one requester, drives the memory port for a fixed wait-state window, then pulses ack to the winner.
- D-side requests have fixed priority, with a starvation guard for the I-side.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_STATES, 2, memory wait cycles per access (0..15).
- MAX_D_BURST, 4, maximum consecutive D grants while I is waiting (1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  I-cache request; level, held until i_ack.
- i_rw  in  1  I-cache direction (1 read, 0 write); stable while i_req.
- i_addr  in  AW  I-cache address.
- i_wdata  in  DW  I-cache write data.
- i_ack  out  1  one-cycle completion pulse to I-cache.
- d_req  in  1  D-cache request; level, held until d_ack.
- d_rw  in  1  D-cache direction (1 read, 0 write).
- d_addr  in  AW  D-cache address.
- d_wdata  in  DW  D-cache write data.
- d_ack  out  1  one-cycle completion pulse to D-cache.
- rdata  out  DW  read data, broadcast to both caches; valid only in the ack cycle.
- mem_strobe  out  1  memory access active.
- mem_rw  out  1  memory direction.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  arbiter not idle.

Behaviour:
- Reset (synchronous):
  - state=IDLE, grant register cleared, wait counter=0, d_streak=0.
  - All outputs 0 (rdata=0 while not in DONE).
  - Reset mid-access aborts the access: no ack is issued, and mem_strobe drops the cycle after rst is sampled.
- States: IDLE, GRANT, WAIT, DONE.
- IDLE:
  - Arbitrate on the sampled req lines.
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant D, unless d_streak==MAX_D_BURST, in which case grant I.
  - Any grant: register the winner (gsel: 0=D, 1=I) and go to GRANT.
- GRANT:
  - mem_strobe=1; mem_rw, mem_addr and mem_wdata are muxed from the gsel requester.
  - Load the wait counter with WAIT_STATES.
  - Next state is WAIT, or DONE if WAIT_STATES==0.
- WAIT:
  - mem_strobe and mem_* held stable from gsel.
  - Counter decrements each cycle; move to DONE when counter==1 at the edge (exactly WAIT_STATES cycles spent in WAIT).
- DONE:
  - mem_strobe stays 1.
  - ack pulses for exactly one cycle to the gsel requester.
  - rdata = mem_rdata when the access is a read, otherwise 0.
  - Next state is IDLE unconditionally.
- Latency: request first sampled high in IDLE at cycle t -> GRANT t+1 -> DONE/ack at t+2+WAIT_STATES. Default: ack at t+4.
- Back-to-back: minimum one IDLE cycle between accesses; the next ack comes no earlier than 1 cycle after the previous DONE + 2 + WAIT_STATES.
- Requester rules:
  - Drop req in the cycle following ack.
  - A req still high in the IDLE cycle after its ack is treated as a new request.
  - A req deasserted before ack is ignored once granted; the access completes anyway.
- Starvation guard (d_streak, 4-bit, saturating at MAX_D_BURST):
  - D grant while i_req=1: d_streak increments.
  - I grant, or any IDLE cycle with i_req=0: d_streak resets to 0.
- Output timing:
  - busy=1 in GRANT, WAIT and DONE.
  - mem_* and ack are decoded from the registered state/gsel only; no combinational path from *_req to mem_* or *_ack.
  - mem_addr, mem_wdata and mem_rw are 0 when mem_strobe=0.
- Grant is never changed mid-access; a request arriving while busy waits for IDLE.

Test Plan:
- Single D read, W=2: d_req=1, d_addr=0x100, mem_rdata=0xDEADBEEF.
  - Required: mem_strobe high t+1..t+4; mem_addr=0x100, mem_rw=1.
  - Required: d_ack and rdata=0xDEADBEEF at t+4 only; i_ack stays 0.
- Single I write, W=0: i_req=1, i_rw=0, i_addr=0x40, i_wdata=0x12345678.
  - Required: GRANT t+1, DONE t+2, i_ack at t+2.
  - Required: mem_wdata=0x12345678 for both strobe cycles; rdata=0.
- Simultaneous requests, both first high at cycle 0 (W=2): D is served first (d_ack cycle 4).
  - D drops req after its ack; I re-arbitrates in the IDLE at cycle 5 and gets i_ack at cycle 9.
- Starvation, MAX_D_BURST=4: i_req held high; d_req re-raised immediately after each d_ack.
  - Required: 4 D acks, then an I ack, then D resumes; d_streak back to 0 after the I grant.
- Reset mid-WAIT with D granted: rst=1 for 1 cycle.
  - Required: next cycle state=IDLE, mem_strobe=0, busy=0; no d_ack ever issued for the aborted access.
- Late request: i_req rises during a D access in WAIT.
  - Required: no change to mem_addr during the D access; I is granted in the first IDLE after d_ack.
